// File: rtl/hw_video_pkg.sv
// Shared types for the VGA test-pattern generator: mode encodings,
// colour-bar code table, pipeline bundle and box-axis step helper.
package hw_video_pkg;

    typedef enum logic [1:0] {
        MODE_SPLIT = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    // Colour code {r,g,b}: each bit selects full scale or zero.
    typedef logic [2:0] rgb_code_t;

    localparam rgb_code_t RGB_WHITE   = 3'b111;
    localparam rgb_code_t RGB_YELLOW  = 3'b110;
    localparam rgb_code_t RGB_CYAN    = 3'b011;
    localparam rgb_code_t RGB_GREEN   = 3'b010;
    localparam rgb_code_t RGB_MAGENTA = 3'b101;
    localparam rgb_code_t RGB_RED     = 3'b100;
    localparam rgb_code_t RGB_BLUE    = 3'b001;
    localparam rgb_code_t RGB_BLACK   = 3'b000;

    // Stage-1 bundle; dim overrides rgb with half-scale blue.
    typedef struct packed {
        logic      ena;
        logic      dim;
        rgb_code_t rgb;
    } pix_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    typedef struct packed {
        dir_e        dir;
        logic [10:0] pos;
    } axis_t;

    function automatic rgb_code_t bar_code(input logic [2:0] idx);
        rgb_code_t c;
        unique case (idx)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            3'd7: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    // One frame step of a bouncing axis. 12-bit maths keeps
    // pos+size+step from wrapping before the limit compare.
    function automatic axis_t axis_next(
        input axis_t       cur,
        input logic [11:0] limit,
        input logic [11:0] size,
        input logic [11:0] step
    );
        axis_t       nxt;
        logic [11:0] pos12;
        nxt   = cur;
        pos12 = {1'b0, cur.pos};
        if (cur.dir == DIR_INC) begin
            if (pos12 + size + step > limit) begin
                nxt.pos = 11'(limit - size);
                nxt.dir = DIR_DEC;
            end else begin
                nxt.pos = 11'(pos12 + step);
            end
        end else begin
            if (pos12 < step) begin
                nxt.pos = '0;
                nxt.dir = DIR_INC;
            end else begin
                nxt.pos = 11'(pos12 - step);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hw_box_animator.sv
// Bouncing-box position: one position/direction FSM per axis, stepped
// on frame_tick. Ports: pixel_clk, reset (async high), frame_tick in;
// box_x, box_y (11-bit top-left corner) out.
module hw_box_animator
    import hw_video_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 2
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        frame_tick,
    output logic [10:0] box_x,
    output logic [10:0] box_y
);

    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM = 12'(V_ACTIVE);
    localparam logic [11:0] SIZE  = 12'(BOX_SIZE);
    localparam logic [11:0] STEP  = 12'(BOX_STEP);

    axis_t x_q;
    axis_t x_d;
    axis_t y_q;
    axis_t y_d;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            x_q <= '{dir: DIR_INC, pos: 11'd0};
            y_q <= '{dir: DIR_INC, pos: 11'd0};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_tick) begin
            x_d = axis_next(x_q, H_LIM, SIZE, STEP);
            y_d = axis_next(y_q, V_LIM, SIZE, STEP);
        end
    end

    assign box_x = x_q.pos;
    assign box_y = y_q.pos;

endmodule

// File: rtl/hw_pattern_generator.sv
// Two-stage registered VGA test-pattern source with four patterns.
// Ports: pixel_clk, reset (async high), disp_ena, row, column, mode in;
// red, green, blue (COLOR_W each) and disp_ena_o (2-cycle aligned) out.
module hw_pattern_generator
    import hw_video_pkg::*;
#(
    parameter int COLOR_W  = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPLIT_X  = 600,
    parameter int SPLIT_Y  = 478,
    parameter int BAR_W    = 80,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 2
) (
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic               disp_ena,
    input  logic [10:0]        row,
    input  logic [10:0]        column,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               disp_ena_o
);

    localparam logic [10:0] LAST_ROW = 11'(V_ACTIVE - 1);
    localparam logic [10:0] LAST_COL = 11'(H_ACTIVE - 1);
    localparam logic [10:0] SPL_X    = 11'(SPLIT_X);
    localparam logic [10:0] SPL_Y    = 11'(SPLIT_Y);
    localparam logic [10:0] BAR_WC   = 11'(BAR_W);
    localparam logic [11:0] BOX_SZ   = 12'(BOX_SIZE);

    localparam logic [COLOR_W-1:0] FULL = '1;
    localparam logic [COLOR_W-1:0] DIM  =
        {1'b1, {(COLOR_W-1){1'b0}}};

    logic        frame_tick;
    mode_e       mode_q;
    logic [10:0] box_x;
    logic [10:0] box_y;
    logic [10:0] bar_q;
    logic [2:0]  bar_idx;
    logic        in_box;
    pix_t        pix_d;
    pix_t        pix_q;

    assign frame_tick = disp_ena
                     && (row == LAST_ROW)
                     && (column == LAST_COL);

    // Pattern only changes between frames.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_SPLIT;
        end else if (frame_tick) begin
            mode_q <= mode_e'(mode);
        end
    end

    hw_box_animator #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // Off-screen columns keep counting bars, so clamp to black.
    assign bar_q   = column / BAR_WC;
    assign bar_idx = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];

    assign in_box = ({1'b0, column} >= {1'b0, box_x})
                 && ({1'b0, column} <  {1'b0, box_x} + BOX_SZ)
                 && ({1'b0, row}    >= {1'b0, box_y})
                 && ({1'b0, row}    <  {1'b0, box_y} + BOX_SZ);

    always_comb begin
        pix_d     = '0;
        pix_d.ena = disp_ena;
        unique case (mode_q)
            MODE_SPLIT: begin
                pix_d.rgb = (row < SPL_Y && column < SPL_X)
                          ? RGB_BLUE : RGB_YELLOW;
            end
            MODE_BARS: begin
                pix_d.rgb = bar_code(bar_idx);
            end
            MODE_CHECK: begin
                pix_d.rgb = (row[CHK_LOG2] ^ column[CHK_LOG2])
                          ? RGB_WHITE : RGB_BLACK;
            end
            MODE_BOX: begin
                if (in_box) begin
                    pix_d.rgb = RGB_WHITE;
                end else begin
                    pix_d.dim = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            disp_ena_o <= 1'b0;
        end else begin
            disp_ena_o <= pix_q.ena;
            red   <= (pix_q.ena && pix_q.rgb[2]) ? FULL : '0;
            green <= (pix_q.ena && pix_q.rgb[1]) ? FULL : '0;
            if (!pix_q.ena) begin
                blue <= '0;
            end else if (pix_q.dim) begin
                blue <= DIM;
            end else begin
                blue <= pix_q.rgb[0] ? FULL : '0;
            end
        end
    end

endmodule

// File: tb/tb_hw_pattern_generator.sv
// Self-checking bench for hw_pattern_generator: per-cycle compare
// against a spec-level model plus hand-computed literal probes.
`timescale 1ns/1ps
module tb_hw_pattern_generator;

    localparam int H = 640;
    localparam int V = 480;
    localparam int BS = 64;
    localparam int ST = 2;

    localparam logic [24:0] WHITE = {1'b1, 24'hFFFFFF};
    localparam logic [24:0] YELLOW = {1'b1, 24'hFFFF00};
    localparam logic [24:0] CYAN = {1'b1, 24'h00FFFF};
    localparam logic [24:0] BLUE = {1'b1, 24'h0000FF};
    localparam logic [24:0] BLACK = {1'b1, 24'h000000};
    localparam logic [24:0] DARK = {1'b1, 24'h000080};

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_ena = 1'b0;
    logic [10:0] row = '0;
    logic [10:0] column = '0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        disp_ena_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    hw_pattern_generator dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .disp_ena   (disp_ena),
        .row        (row),
        .column     (column),
        .mode       (mode),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .disp_ena_o (disp_ena_o)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [23:0] model_px(
        input int m, input int r, input int c,
        input int bx, input int by
    );
        int idx;
        case (m)
            0: return (r < 478 && c < 600) ? 24'h0000FF : 24'hFFFF00;
            1: begin
                idx = c / 80;
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: return ((((r / 32) % 2) + ((c / 32) % 2)) == 1)
                      ? 24'hFFFFFF : 24'h000000;
            default: return (c >= bx && c < bx + BS
                             && r >= by && r < by + BS)
                            ? 24'hFFFFFF : 24'h000080;
        endcase
    endfunction

    int mode_m;
    int bx;
    int by;
    int dx;
    int dy;
    logic [24:0] p1;
    logic [24:0] p2;

    always @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            p1 <= '0;
            p2 <= '0;
            mode_m <= 0;
            bx <= 0;
            by <= 0;
            dx <= 1;
            dy <= 1;
        end else begin
            p2 <= p1;
            p1 <= disp_ena
                ? {1'b1, model_px(mode_m, int'(row), int'(column), bx, by)}
                : 25'd0;
            if (disp_ena && row == 11'(V - 1) && column == 11'(H - 1)) begin
                mode_m <= int'(mode);
                if (dx > 0 && bx + BS + ST > H) begin
                    bx <= H - BS;
                    dx <= -1;
                end else if (dx < 0 && bx < ST) begin
                    bx <= 0;
                    dx <= 1;
                end else begin
                    bx <= bx + ST * dx;
                end
                if (dy > 0 && by + BS + ST > V) begin
                    by <= V - BS;
                    dy <= -1;
                end else if (dy < 0 && by < ST) begin
                    by <= 0;
                    dy <= 1;
                end else begin
                    by <= by + ST * dy;
                end
            end
        end
    end

    always @(negedge pixel_clk) begin
        if (run) begin
            n_cmp++;
            if ({disp_ena_o, red, green, blue} !== p2) begin
                n_bad++;
                $display("FAIL pixel t=%0t got=%h want=%h", $time,
                         {disp_ena_o, red, green, blue}, p2);
            end
        end
    end

    task automatic drive(input logic e, input int r, input int c);
        disp_ena = e;
        row = 11'(r);
        column = 11'(c);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [24:0] want);
        n_cmp++;
        if ({disp_ena_o, red, green, blue} !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm,
                     {disp_ena_o, red, green, blue}, want);
        end
    endtask

    task automatic probe(input string nm, input int r, input int c,
                         input logic [24:0] want);
        drive(1'b1, r, c);
        drive(1'b1, r, c);
        lit(nm, want);
    endtask

    task automatic tick();
        drive(1'b1, V - 1, H - 1);
    endtask

    initial begin
        mode = 2'd3;
        disp_ena = 1'b1;
        row = 11'd10;
        column = 11'd10;
        reset = 1'b1;
        repeat (2) @(posedge pixel_clk);
        #1;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10, 10);
            lit("reset_zero", 25'd0);
        end
        reset = 1'b0;

        probe("mode0_after_reset", 10, 10, BLUE);
        probe("mode0_row478", 478, 10, YELLOW);
        probe("mode0_col600", 10, 600, YELLOW);
        probe("mode0_corner", 477, 599, BLUE);

        mode = 2'd2;
        probe("midframe_hold", 10, 10, BLUE);
        tick();
        probe("check_after_tick", 10, 10, BLACK);
        probe("check_40_10", 40, 10, WHITE);
        probe("check_31_0", 31, 0, BLACK);
        probe("check_32_0", 32, 0, WHITE);
        probe("check_32_32", 32, 32, BLACK);

        mode = 2'd1;
        tick();
        for (int c = 0; c < H; c++) drive(1'b1, 5, c);
        drive(1'b1, 5, 700);
        probe("bar_79", 5, 79, WHITE);
        probe("bar_80", 5, 80, YELLOW);
        probe("bar_159", 5, 159, YELLOW);
        probe("bar_160", 5, 160, CYAN);
        probe("bar_559", 5, 559, BLUE);
        probe("bar_560", 5, 560, BLACK);
        probe("bar_700", 5, 700, BLACK);

        drive(1'b1, 5, 80);
        drive(1'b0, 5, 80);
        lit("lag_on", YELLOW);
        drive(1'b0, 5, 80);
        lit("lag_off", 25'd0);
        for (int i = 0; i < 6; i++) drive(1'(i % 2), 5, 100);

        drive(1'b1, 5, 200);
        reset = 1'b1;
        #1;
        lit("midframe_reset", 25'd0);
        drive(1'b1, 5, 200);
        lit("reset_hold", 25'd0);
        reset = 1'b0;
        drive(1'b1, 5, 200);
        lit("reset_release1", 25'd0);

        mode = 2'd3;
        for (int n = 1; n <= 420; n++) begin
            tick();
            drive(1'b1, by, bx);
            drive(1'b1, by, bx + BS - 1);
            drive(1'b1, by, bx + BS);
            drive(1'b1, by + BS, bx);
            drive(1'b0, by, bx);
            if (n == 208) begin
                probe("box208_in", 416, 416, WHITE);
                probe("box208_above", 415, 416, DARK);
                probe("box208_corner", 479, 479, WHITE);
            end
            if (n == 289) begin
                probe("box289_in", 256, 576, WHITE);
                probe("box289_left", 256, 575, DARK);
            end
            if (n == 290) begin
                probe("box290_in", 254, 574, WHITE);
                probe("box290_left", 254, 573, DARK);
                probe("box290_above", 253, 574, DARK);
            end
            if (n == 418) begin
                probe("box418_in", 0, 318, WHITE);
                probe("box418_left", 0, 317, DARK);
            end
            if (n == 419) begin
                probe("box419_in", 2, 316, WHITE);
                probe("box419_above", 1, 316, DARK);
            end
        end

        drive(1'b0, 0, 0);
        drive(1'b0, 0, 0);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
